// File: rtl/seq_scan_arbiter_pkg.sv
// Shared types and constants for the round-robin scan arbiter
// and the serial 1011 detector it drives.
package seq_det_pkg;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        CLEAR = 5'b00010,
        SHIFT = 5'b00100,
        DRAIN = 5'b01000,
        DONE  = 5'b10000
    } scan_state_t;

    typedef enum logic [4:0] {
        D_S0   = 5'b00001,
        D_S1   = 5'b00010,
        D_S10  = 5'b00100,
        D_S101 = 5'b01000,
        D_HIT  = 5'b10000
    } det_state_t;

    localparam int DRAIN_CYCLES = 2;
    localparam logic [3:0] PATTERN = 4'b1011;

endpackage

// File: rtl/seq_scan_arbiter_if.sv
// Requester-side bundle: requests, words, grants and results.
// The arbiter takes the slave view, the requesters the master view.
interface seq_scan_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 16
);
    localparam int IDW  = $clog2(N_REQ);
    localparam int CNTW = $clog2(WORD_W) + 1;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] word_in;
    logic [N_REQ-1:0]        gnt;
    logic                    busy;
    logic                    done;
    logic [IDW-1:0]          done_id;
    logic [CNTW-1:0]         match_cnt;

    modport master (
        output req, word_in,
        input  gnt, busy, done, done_id, match_cnt
    );

    modport slave (
        input  req, word_in,
        output gnt, busy, done, done_id, match_cnt
    );
endinterface

// File: rtl/seq_scan_arbiter_det.sv
// Non-overlapping 1011 Moore detector with a registered output,
// so a completing bit in cycle c shows on detect_out in cycle c+2.
module seq_detector
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic seq_in,
    output logic detect_out
);
    det_state_t r_state;
    det_state_t w_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= D_S0;
            detect_out <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            detect_out <= (r_state == D_HIT);
        end
    end

    // The bit arriving while in D_HIT is discarded (non-overlapping).
    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            D_S0:   w_nxt = (seq_in == PATTERN[3]) ? D_S1 : D_S0;
            D_S1:   w_nxt = (seq_in == PATTERN[2]) ? D_S10 : D_S1;
            D_S10:  w_nxt = (seq_in == PATTERN[1]) ? D_S101 : D_S0;
            D_S101: w_nxt = (seq_in == PATTERN[0]) ? D_HIT : D_S10;
            D_HIT:  w_nxt = D_S0;
            default: w_nxt = D_S0;
        endcase
    end
endmodule

// File: rtl/seq_scan_arbiter_rr.sv
// Combinational round-robin picker: first set request at or
// after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant_onehot,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);
    localparam int IW = $clog2(N);
    localparam int JW = IW + 1;

    logic [JW-1:0] w_j;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        w_j          = '0;
        for (int k = 0; k < N; k++) begin
            w_j = {1'b0, ptr} + JW'(k);
            if (w_j >= JW'(N)) begin
                w_j = w_j - JW'(N);
            end
            if (!any && req[w_j[IW-1:0]]) begin
                any                        = 1'b1;
                grant_idx                  = w_j[IW-1:0];
                grant_onehot[w_j[IW-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seq_scan_arbiter.sv
// Shares one serial 1011 detector between N_REQ requesters: grant,
// clear detector, shift word MSB-first, count hits, report.
module seq_scan_arbiter
    import seq_det_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    seq_scan_arbiter_if.slave  bus,
    output logic               seq_out,
    output logic               det_rst,
    input  logic               detect_in
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(WORD_W) + 1;
    localparam logic [CW-1:0] CMAX     = '1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
    localparam logic [1:0]    LAST_DRN = 2'(DRAIN_CYCLES - 1);
    localparam logic [IW-1:0] LAST_ID  = IW'(N_REQ - 1);

    scan_state_t r_state;
    scan_state_t w_nxt;

    logic [WORD_W-1:0] r_shreg;
    logic [IW-1:0]     r_cur_id;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_done_id;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_bit_cnt;
    logic [CW-1:0]     r_match_cnt;
    logic [1:0]        r_drn;
    logic [N_REQ-1:0]  r_gnt;

    logic [N_REQ-1:0]  w_onehot;
    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic [CW-1:0]     w_cnt_nxt;
    logic [IW-1:0]     w_ptr_nxt;
    logic [WORD_W-1:0] w_words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign w_words[g] = bus.word_in[g*WORD_W +: WORD_W];
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req          (bus.req),
        .ptr          (r_rr_ptr),
        .grant_onehot (w_onehot),
        .grant_idx    (w_idx),
        .any          (w_any)
    );

    assign w_cnt_nxt = (detect_in && (r_cnt != CMAX)) ? r_cnt + CW'(1) : r_cnt;
    assign w_ptr_nxt = (r_cur_id == LAST_ID) ? '0 : r_cur_id + IW'(1);

    assign seq_out       = (r_state == SHIFT) & r_shreg[WORD_W-1];
    assign det_rst       = reset | (r_state == CLEAR);
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.gnt       = r_gnt;
    assign bus.done_id   = r_done_id;
    assign bus.match_cnt = r_match_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            IDLE:  if (w_any) w_nxt = CLEAR;
            CLEAR: w_nxt = SHIFT;
            SHIFT: if (r_bit_cnt == LAST_BIT) w_nxt = DRAIN;
            DRAIN: if (r_drn == LAST_DRN) w_nxt = DONE;
            DONE:  w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Result registers load on the last drain edge so they are
    // valid during DONE and hold until the next scan completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg     <= '0;
            r_cur_id    <= '0;
            r_rr_ptr    <= '0;
            r_done_id   <= '0;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_match_cnt <= '0;
            r_drn       <= '0;
            r_gnt       <= '0;
        end else begin
            r_gnt <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_shreg   <= w_words[w_idx];
                        r_cur_id  <= w_idx;
                        r_gnt     <= w_onehot;
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_drn     <= '0;
                    end
                end
                SHIFT: begin
                    r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                    r_cnt     <= w_cnt_nxt;
                end
                DRAIN: begin
                    r_drn <= r_drn + 2'd1;
                    r_cnt <= w_cnt_nxt;
                    if (r_drn == LAST_DRN) begin
                        r_match_cnt <= w_cnt_nxt;
                        r_done_id   <= r_cur_id;
                    end
                end
                DONE:    r_rr_ptr <= w_ptr_nxt;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Bench for seq_scan_arbiter wired to a real seq_detector: vector
// table, directed multi-cycle sequences, randomized traffic.
module tb_seq_scan_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic seq_out, det_rst, detect_in;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   m_ptr = 0;

    seq_scan_arbiter_if #(.N_REQ(4), .WORD_W(16)) bus ();

    seq_scan_arbiter #(.N_REQ(4), .WORD_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .seq_out   (seq_out),
        .det_rst   (det_rst),
        .detect_in (detect_in)
    );

    seq_detector u_det (
        .clk        (clk),
        .reset      (det_rst),
        .seq_in     (seq_out),
        .detect_out (detect_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [3:0] req;
        logic [15:0] word;
        int         exp_id;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Non-overlapping search; the bit after a hit is skipped too.
    function automatic int ref_count(input logic [15:0] w);
        int c = 0;
        int i = 0;
        while (i <= 12) begin
            if (w[15-i -: 4] == 4'b1011) begin
                c++;
                i += 5;
            end else begin
                i++;
            end
        end
        return c;
    endfunction

    function automatic int ref_arb(input logic [3:0] m, input int p);
        for (int k = 0; k < 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_done_id", bus.done_id, 0);
        chk("rst_match_cnt", bus.match_cnt, 0);
        chk("rst_seq_out", seq_out, 0);
        chk("rst_det_rst", det_rst, 1);
        reset = 1'b0;
        m_ptr = 0;
    endtask

    // Raise requests in an IDLE cycle (cycle 0) and follow one scan.
    task automatic txn(input string nm, input logic [3:0] rq,
                       input bit hold, input int exp_id,
                       input int exp_cnt);
        int  t0;
        int  gseen;
        bit  fin;
        gseen = 0;
        fin   = 1'b0;
        @(negedge clk);
        bus.req = rq;
        t0 = cyc;
        for (int k = 0; k < 40 && !fin; k++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                gseen++;
                chk({nm, "_gnt"}, bus.gnt, 32'(1) << exp_id);
                chk({nm, "_gnt_cyc"}, cyc - t0, 1);
                chk({nm, "_busy"}, bus.busy, 1);
                if (!hold) bus.req = '0;
            end
            if (bus.done) begin
                fin = 1'b1;
                chk({nm, "_done_cyc"}, cyc - t0, 20);
                chk({nm, "_done_id"}, bus.done_id, exp_id);
                chk({nm, "_match_cnt"}, bus.match_cnt, exp_cnt);
            end
        end
        chk({nm, "_finished"}, fin, 1);
        chk({nm, "_gnt_pulses"}, gseen, 1);
        m_ptr = (exp_id + 1) % 4;
    endtask

    initial begin
        int t0;
        int dn;
        bus.req     = '0;
        bus.word_in = '0;

        tbl[0] = '{"two_hits",  4'b0001, 16'b1011_0_1011_000000, 0, 2};
        tbl[1] = '{"overlap",   4'b0001, 16'b1011011_000000000,  0, 1};
        tbl[2] = '{"tail",      4'b0100, 16'h000B,               2, 1};
        tbl[3] = '{"all_ones",  4'b1000, 16'hFFFF,               3, 0};
        tbl[4] = '{"twice_b0",  4'b0010, 16'hB0B0,               1, 2};

        do_reset();

        for (int v = 0; v < 5; v++) begin
            bus.word_in = {4{tbl[v].word}};
            txn(tbl[v].name, tbl[v].req, 1'b0, tbl[v].exp_id,
                tbl[v].exp_cnt);
        end

        // Four simultaneous requesters, each drops out once granted.
        do_reset();
        bus.word_in = {4{16'hB000}};
        txn("all4_0", 4'b1111, 1'b0, 0, 1);
        txn("all4_1", 4'b1110, 1'b0, 1, 1);
        txn("all4_2", 4'b1100, 1'b0, 2, 1);
        txn("all4_3", 4'b1000, 1'b0, 3, 1);

        // Requests 0 and 3 held continuously must alternate.
        do_reset();
        txn("fair_0", 4'b1001, 1'b1, 0, 1);
        txn("fair_1", 4'b1001, 1'b1, 3, 1);
        txn("fair_2", 4'b1001, 1'b1, 0, 1);
        txn("fair_3", 4'b1001, 1'b1, 3, 1);
        bus.req = '0;

        // Reset in the middle of a scan.
        do_reset();
        txn("pre_rst", 4'b0100, 1'b0, 2, 1);
        @(negedge clk);
        bus.req = 4'b0100;
        t0 = cyc;
        while (cyc - t0 < 8) begin
            @(negedge clk);
            if (bus.gnt != '0) bus.req = '0;
        end
        chk("mid_shift_busy", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_det_rst", det_rst, 1);
        chk("mid_rst_match_cnt", bus.match_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        m_ptr = 0;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("mid_rst_no_done", dn, 0);
        txn("post_rst", 4'b1111, 1'b0, 0, 1);

        // Random traffic against the reference arbitration/count model.
        for (int r = 0; r < 25; r++) begin
            logic [3:0]  m;
            logic [15:0] w;
            int          id;
            m           = 4'($urandom_range(1, 15));
            bus.word_in = {$urandom(), $urandom()};
            id          = ref_arb(m, m_ptr);
            w           = bus.word_in[id*16 +: 16];
            txn("rand", m, 1'b0, id, ref_count(w));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
